// File: rtl/dll_mode_seq_if.sv
// Request/handshake and DDR4 command-bus bundle for the DLL mode-switch sequencer.
// The sequencer attaches through the slave modport; its driver uses master.
interface dll_mode_seq_if #(
  parameter int unsigned BANK_WIDTH = 2,
  parameter int unsigned BG_WIDTH   = 2,
  parameter int unsigned CS_WIDTH   = 1,
  parameter int unsigned CKE_WIDTH  = 2
);
  logic                      req_valid;
  logic                      req_ready;
  logic [13:0]               req_mr0;
  logic [13:0]               req_mr2;
  logic                      seq_done;
  logic                      busy;
  logic                      timeout_err;
  logic                      toggle_valid;
  logic                      dllt_done;

  logic [7:0]                n_ACT_n;
  logic [135:0]              n_ADR;
  logic [BANK_WIDTH*8-1:0]   n_BA;
  logic [BG_WIDTH*8-1:0]     n_BG;
  logic [CS_WIDTH*8-1:0]     n_CS_n;
  logic [CKE_WIDTH*8-1:0]    n_CKE;

  logic [7:0]                t_ACT_n;
  logic [135:0]              t_ADR;
  logic [BANK_WIDTH*8-1:0]   t_BA;
  logic [BG_WIDTH*8-1:0]     t_BG;
  logic [CS_WIDTH*8-1:0]     t_CS_n;
  logic [CKE_WIDTH*8-1:0]    t_CKE;

  logic [7:0]                mc_ACT_n;
  logic [135:0]              mc_ADR;
  logic [BANK_WIDTH*8-1:0]   mc_BA;
  logic [BG_WIDTH*8-1:0]     mc_BG;
  logic [CS_WIDTH*8-1:0]     mc_CS_n;
  logic [CKE_WIDTH*8-1:0]    mc_CKE;

  modport master (
    output req_valid, req_mr0, req_mr2, dllt_done,
    output n_ACT_n, n_ADR, n_BA, n_BG, n_CS_n, n_CKE,
    output t_ACT_n, t_ADR, t_BA, t_BG, t_CS_n, t_CKE,
    input  req_ready, seq_done, busy, timeout_err, toggle_valid,
    input  mc_ACT_n, mc_ADR, mc_BA, mc_BG, mc_CS_n, mc_CKE
  );

  modport slave (
    input  req_valid, req_mr0, req_mr2, dllt_done,
    input  n_ACT_n, n_ADR, n_BA, n_BG, n_CS_n, n_CKE,
    input  t_ACT_n, t_ADR, t_BA, t_BG, t_CS_n, t_CKE,
    output req_ready, seq_done, busy, timeout_err, toggle_valid,
    output mc_ACT_n, mc_ADR, mc_BA, mc_BG, mc_CS_n, mc_CKE
  );
endinterface

// File: rtl/dll_mode_seq.sv
// DLL mode-switch sequencer: starts the toggler, lends it the command bus, then
// rewrites MR0/MR2 with tMOD spacing. Also owns the command-bus mux to the PHY.
module dll_mode_seq #(
  parameter int unsigned BANK_WIDTH = 2,
  parameter int unsigned BG_WIDTH   = 2,
  parameter int unsigned CS_WIDTH   = 1,
  parameter int unsigned CKE_WIDTH  = 2,
  parameter int unsigned T_MOD      = 24,
  parameter int unsigned T_TIMEOUT  = 4095
) (
  input logic           clk,
  input logic           rst_n,
  dll_mode_seq_if.slave bus
);
  localparam int unsigned BaW  = BANK_WIDTH * 8;
  localparam int unsigned BgW  = BG_WIDTH * 8;
  localparam int unsigned CsW  = CS_WIDTH * 8;
  localparam int unsigned CkeW = CKE_WIDTH * 8;

  localparam logic [11:0] TModCnt     = 12'(T_MOD);
  localparam logic [11:0] TTimeoutCnt = 12'(T_TIMEOUT);

  typedef enum logic [2:0] {
    StIdle, StToggle, StWaitDllt, StMrs0, StWaitMr0, StMrs2, StWaitMr2, StDone
  } state_e;

  typedef enum logic [1:0] {SelNorm, SelTgl, SelMrs} sel_e;

  typedef struct packed {
    logic [7:0]      act_n;
    logic [135:0]    adr;
    logic [BaW-1:0]  ba;
    logic [BgW-1:0]  bg;
    logic [CsW-1:0]  cs_n;
    logic [CkeW-1:0] cke;
  } cmd_t;

  localparam cmd_t CmdIdle = '{act_n: '1, adr: '1, ba: '0, bg: '0, cs_n: '1, cke: '1};

  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d, cnt_dec;
  logic [13:0] mr0_q, mr0_d, mr2_q, mr2_d;
  logic        toggle_valid_q, toggle_valid_d;
  logic        seq_done_q, seq_done_d;
  logic        timeout_err_q, timeout_err_d;
  cmd_t        cmd_q, cmd_d;
  logic        mrs_fire, mrs_to_mr2;
  logic [13:0] mrs_val;
  sel_e        sel;

  // One counter serves as both the dllt watchdog and the tMOD timer; it never wraps.
  assign cnt_dec = (cnt_q == 12'd0) ? 12'd0 : cnt_q - 12'd1;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mr0_d          = mr0_q;
    mr2_d          = mr2_q;
    toggle_valid_d = 1'b0;
    seq_done_d     = 1'b0;
    timeout_err_d  = timeout_err_q;
    mrs_fire       = 1'b0;
    mrs_to_mr2     = 1'b0;
    mrs_val        = mr0_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          mr0_d          = bus.req_mr0;
          mr2_d          = bus.req_mr2;
          toggle_valid_d = 1'b1;
          state_d        = StToggle;
        end
      end
      StToggle: begin
        cnt_d   = TTimeoutCnt;
        state_d = StWaitDllt;
      end
      StWaitDllt: begin
        // A done pulse on the last watchdog cycle still counts as success.
        if (bus.dllt_done) begin
          state_d = StMrs0;
        end else if (cnt_q == 12'd0) begin
          timeout_err_d = 1'b1;
          state_d       = StIdle;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      StMrs0: begin
        mrs_fire = 1'b1;
        cnt_d    = TModCnt;
        state_d  = StWaitMr0;
      end
      StWaitMr0: begin
        if (cnt_q == 12'd0) state_d = StMrs2;
        else                cnt_d   = cnt_dec;
      end
      StMrs2: begin
        mrs_fire   = 1'b1;
        mrs_to_mr2 = 1'b1;
        mrs_val    = mr2_q;
        cnt_d      = TModCnt;
        state_d    = StWaitMr2;
      end
      StWaitMr2: begin
        if (cnt_q == 12'd0) begin
          seq_done_d = 1'b1;
          state_d    = StDone;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // MRS: CS_n/RAS/CAS/WE low on slots 0-1, address bit i on ADR[i*8+:2].
  always_comb begin
    cmd_d = CmdIdle;
    if (mrs_fire) begin
      cmd_d.cs_n[1:0]     = 2'b00;
      cmd_d.adr[16*8 +: 2] = 2'b00;
      cmd_d.adr[15*8 +: 2] = 2'b00;
      cmd_d.adr[14*8 +: 2] = 2'b00;
      for (int i = 0; i < 14; i++) begin
        cmd_d.adr[i*8 +: 2] = {2{mrs_val[i]}};
      end
      cmd_d.ba[8 +: 2] = {2{mrs_to_mr2}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= 12'd0;
      mr0_q          <= 14'd0;
      mr2_q          <= 14'd0;
      toggle_valid_q <= 1'b0;
      seq_done_q     <= 1'b0;
      timeout_err_q  <= 1'b0;
      cmd_q          <= CmdIdle;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mr0_q          <= mr0_d;
      mr2_q          <= mr2_d;
      toggle_valid_q <= toggle_valid_d;
      seq_done_q     <= seq_done_d;
      timeout_err_q  <= timeout_err_d;
      cmd_q          <= cmd_d;
    end
  end

  always_comb begin
    unique case (state_q)
      StToggle, StWaitDllt:                     sel = SelTgl;
      StMrs0, StWaitMr0, StMrs2, StWaitMr2:     sel = SelMrs;
      default:                                  sel = SelNorm;
    endcase
  end

  always_comb begin
    bus.mc_ACT_n = bus.n_ACT_n;
    bus.mc_ADR   = bus.n_ADR;
    bus.mc_BA    = bus.n_BA;
    bus.mc_BG    = bus.n_BG;
    bus.mc_CS_n  = bus.n_CS_n;
    bus.mc_CKE   = bus.n_CKE;
    unique case (sel)
      SelTgl: begin
        bus.mc_ACT_n = bus.t_ACT_n;
        bus.mc_ADR   = bus.t_ADR;
        bus.mc_BA    = bus.t_BA;
        bus.mc_BG    = bus.t_BG;
        bus.mc_CS_n  = bus.t_CS_n;
        bus.mc_CKE   = bus.t_CKE;
      end
      SelMrs: begin
        bus.mc_ACT_n = cmd_q.act_n;
        bus.mc_ADR   = cmd_q.adr;
        bus.mc_BA    = cmd_q.ba;
        bus.mc_BG    = cmd_q.bg;
        bus.mc_CS_n  = cmd_q.cs_n;
        bus.mc_CKE   = cmd_q.cke;
      end
      default: ;
    endcase
  end

  assign bus.req_ready    = (state_q == StIdle);
  assign bus.busy         = (state_q != StIdle);
  assign bus.toggle_valid = toggle_valid_q;
  assign bus.seq_done     = seq_done_q;
  assign bus.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_dll_mode_seq.sv
// Randomized bench for dll_mode_seq: a cycle-level timeline model fills a scoreboard
// and expected-per-cycle tables; a negedge monitor checks the DUT against them.
module tb_dll_mode_seq;
  localparam int T_MOD = 24;
  localparam int T_TO  = 4095;

  localparam int KTog  = 0;
  localparam int KMrs  = 1;
  localparam int KDone = 2;

  localparam logic [1:0] SrcN = 2'd0;  // normal path
  localparam logic [1:0] SrcT = 2'd1;  // toggler path
  localparam logic [1:0] SrcI = 2'd2;  // sequencer, no command
  localparam logic [1:0] SrcM = 2'd3;  // sequencer, MRS (checked as event)

  typedef struct packed {
    logic [7:0]   act_n;
    logic [135:0] adr;
    logic [15:0]  ba;
    logic [15:0]  bg;
    logic [7:0]   cs_n;
    logic [15:0]  cke;
  } cmd_t;

  typedef struct {
    int   kind;
    int   cyc;
    cmd_t img;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  ev_t        ev_q[$];
  logic [1:0] src_at[int];
  bit         busy_at[int];
  int         err_on = -1;
  int         err_off = -1;

  dll_mode_seq_if #(.BANK_WIDTH(2), .BG_WIDTH(2), .CS_WIDTH(1), .CKE_WIDTH(2)) bus ();

  dll_mode_seq #(
    .BANK_WIDTH(2), .BG_WIDTH(2), .CS_WIDTH(1), .CKE_WIDTH(2),
    .T_MOD(T_MOD), .T_TIMEOUT(T_TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      KTog:    return "toggle_valid";
      KMrs:    return "mrs";
      default: return "seq_done";
    endcase
  endfunction

  task automatic chk(input bit ok, input string name, input string got, input string want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %s, want %s", name, cyc, got, want);
    end
  endtask

  function automatic cmd_t idle_img();
    cmd_t c;
    c.act_n = '1; c.adr = '1; c.ba = '0; c.bg = '0; c.cs_n = '1; c.cke = '1;
    return c;
  endfunction

  // Mode-register set: chip select plus RAS/CAS/WE asserted, A[13:0] carried on
  // slots 0-1 of each address lane, bank address 0 for MR0 and 2 for MR2.
  function automatic cmd_t mrs_img(input int mr_num, input logic [13:0] mr);
    cmd_t c;
    c = idle_img();
    c.cs_n[1:0] = 2'b00;
    for (int lane = 14; lane <= 16; lane++) c.adr[lane*8 +: 2] = 2'b00;
    for (int i = 0; i < 14; i++) c.adr[i*8 +: 2] = mr[i] ? 2'b11 : 2'b00;
    if (mr_num == 2) c.ba[8 +: 2] = 2'b11;
    return c;
  endfunction

  function automatic cmd_t get_n();
    cmd_t c;
    c.act_n = bus.n_ACT_n; c.adr = bus.n_ADR; c.ba = bus.n_BA;
    c.bg = bus.n_BG; c.cs_n = bus.n_CS_n; c.cke = bus.n_CKE;
    return c;
  endfunction

  function automatic cmd_t get_t();
    cmd_t c;
    c.act_n = bus.t_ACT_n; c.adr = bus.t_ADR; c.ba = bus.t_BA;
    c.bg = bus.t_BG; c.cs_n = bus.t_CS_n; c.cke = bus.t_CKE;
    return c;
  endfunction

  function automatic cmd_t get_mc();
    cmd_t c;
    c.act_n = bus.mc_ACT_n; c.adr = bus.mc_ADR; c.ba = bus.mc_BA;
    c.bg = bus.mc_BG; c.cs_n = bus.mc_CS_n; c.cke = bus.mc_CKE;
    return c;
  endfunction

  // Random upstream traffic never holds CS_n[0] low, so it can't look like an MRS.
  task automatic rand_cmd(output cmd_t c);
    logic [159:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    c.adr   = w[135:0];
    c.act_n = 8'($urandom());
    c.ba    = 16'($urandom());
    c.bg    = 16'($urandom());
    c.cs_n  = 8'($urandom()) | 8'h01;
    c.cke   = 16'($urandom());
  endtask

  task automatic set_n(input cmd_t c);
    bus.n_ACT_n = c.act_n; bus.n_ADR = c.adr; bus.n_BA = c.ba;
    bus.n_BG = c.bg; bus.n_CS_n = c.cs_n; bus.n_CKE = c.cke;
  endtask

  task automatic set_t(input cmd_t c);
    bus.t_ACT_n = c.act_n; bus.t_ADR = c.adr; bus.t_BA = c.ba;
    bus.t_BG = c.bg; bus.t_CS_n = c.cs_n; bus.t_CKE = c.cke;
  endtask

  task automatic randomize_paths();
    cmd_t c;
    rand_cmd(c); set_n(c);
    rand_cmd(c); set_t(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int kind, input int at, input cmd_t img);
    ev_t e;
    e.kind = kind; e.cyc = at; e.img = img;
    ev_q.push_back(e);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      randomize_paths();
      bus.req_valid = 1'b0;
      bus.dllt_done = ($urandom_range(0, 3) == 0);
    end
  endtask

  // Issue one request in the current (idle) cycle. d = toggler latency after
  // toggle_valid (<1 means never); rst_off >= 0 resets that many cycles after MR0.
  task automatic run_txn(input logic [13:0] m0, input logic [13:0] m2, input int d,
                         input bit spam, input int rst_off);
    int a, dd, c0, c2, cdn, last, r;
    bit ok;
    a  = cyc + 1;
    ok = (d >= 1) && (d <= T_TO + 1);
    dd = ok ? d : T_TO + 1;
    c0 = 0;
    bus.req_valid = 1'b1;
    bus.req_mr0   = m0;
    bus.req_mr2   = m2;
    push_ev(KTog, a, idle_img());
    for (int k = a; k <= a + dd; k++) begin
      src_at[k]  = SrcT;
      busy_at[k] = 1'b1;
    end
    if (ok) begin
      c0  = a + d + 2;
      c2  = c0 + T_MOD + 2;
      cdn = c2 + T_MOD + 1;
      for (int k = a + d + 1; k <= cdn; k++) busy_at[k] = 1'b1;
      for (int k = a + d + 1; k < cdn; k++) src_at[k] = SrcI;
      src_at[c0] = SrcM;
      src_at[c2] = SrcM;
      push_ev(KMrs, c0, mrs_img(0, m0));
      push_ev(KMrs, c2, mrs_img(2, m2));
      push_ev(KDone, cdn, idle_img());
      last = cdn;
    end else begin
      last = a + dd;
      if (!(err_on >= 0 && err_off < 0)) begin
        err_on  = a + dd + 1;
        err_off = -1;
      end
    end
    r = (ok && rst_off >= 0) ? c0 + rst_off : -1;
    forever begin
      step();
      if (r >= 0 && cyc == r + 1) rst_n = 1'b1;
      if (cyc > last) break;
      randomize_paths();
      bus.req_valid = spam;
      if (spam) begin
        bus.req_mr0 = 14'($urandom());
        bus.req_mr2 = 14'($urandom());
      end
      bus.dllt_done = (cyc == a + d) ||
                      ((cyc <= a || cyc > a + dd) && ($urandom_range(0, 3) == 0));
      if (cyc == r) begin
        rst_n = 1'b0;
        while (ev_q.size() > 0 && ev_q[ev_q.size()-1].cyc > r) void'(ev_q.pop_back());
        for (int k = r + 1; k <= r + 3 * T_MOD + 8; k++) begin
          if (src_at.exists(k)) src_at.delete(k);
          if (busy_at.exists(k)) busy_at.delete(k);
        end
        if (err_on >= 0 && err_off < 0) err_off = r + 1;
        last = r;
      end
    end
    bus.req_valid = 1'b0;
    bus.dllt_done = 1'b0;
  endtask

  task automatic match_ev(input int kind, input cmd_t img);
    ev_t e;
    chk(ev_q.size() != 0, {"unexpected_", kname(kind)}, "event", "no event pending");
    if (ev_q.size() != 0) begin
      e = ev_q.pop_front();
      chk(e.kind == kind && e.cyc == cyc && (kind != KMrs || e.img == img),
          {"event_", kname(e.kind)},
          $sformatf("%s @%0d img=%h", kname(kind), cyc, img),
          $sformatf("%s @%0d img=%h", kname(e.kind), e.cyc, e.img));
    end
  endtask

  cmd_t       m_mc, m_exp;
  logic [1:0] m_src;
  bit         m_busy, m_err;

  always @(negedge clk) begin
    if (mon_en) begin
      m_mc = get_mc();
      if (ev_q.size() > 0) begin
        chk(ev_q[0].cyc >= cyc, {"on_time_", kname(ev_q[0].kind)}, "not seen",
            $sformatf("by cycle %0d", ev_q[0].cyc));
        if (ev_q[0].cyc < cyc) void'(ev_q.pop_front());
      end
      if (bus.toggle_valid) match_ev(KTog, m_mc);
      if (m_mc.cs_n[1:0] == 2'b00 && m_mc.adr[128 +: 2] == 2'b00) match_ev(KMrs, m_mc);
      if (bus.seq_done) match_ev(KDone, m_mc);
      m_src = src_at.exists(cyc) ? src_at[cyc] : SrcN;
      if (m_src != SrcM) begin
        m_exp = (m_src == SrcN) ? get_n() : (m_src == SrcT) ? get_t() : idle_img();
        chk(m_mc == m_exp, $sformatf("mux_src%0d", m_src), $sformatf("%h", m_mc),
            $sformatf("%h", m_exp));
      end
      m_busy = busy_at.exists(cyc);
      chk(bus.busy == m_busy, "busy", $sformatf("%0b", bus.busy), $sformatf("%0b", m_busy));
      chk(bus.req_ready == !m_busy, "req_ready", $sformatf("%0b", bus.req_ready),
          $sformatf("%0b", !m_busy));
      m_err = (err_on >= 0) && (cyc >= err_on) && (err_off < 0 || cyc < err_off);
      chk(bus.timeout_err == m_err, "timeout_err", $sformatf("%0b", bus.timeout_err),
          $sformatf("%0b", m_err));
    end
  end

  initial begin
    cmd_t c;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_mr0   = '0;
    bus.req_mr2   = '0;
    bus.dllt_done = 1'b0;
    randomize_paths();
    repeat (3) step();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle_steps(2);

    // Idle pass-through of an all-selected chip-select pattern.
    step();
    rand_cmd(c);
    c.cs_n = 8'h00;
    c.adr  = '1;
    set_n(c);

    run_txn(14'h0A34, 14'h0018, 20, 1'b0, -1);
    idle_steps(3);
    run_txn(14'h1555, 14'h2AAA, 20, 1'b1, -1);
    for (int i = 0; i < 8; i++) begin
      run_txn(14'($urandom()), 14'($urandom()), int'($urandom_range(1, 40)),
              1'($urandom_range(0, 1)), -1);
      idle_steps(int'($urandom_range(0, 3)));
    end
    run_txn(14'h3FFF, 14'h0001, T_TO + 1, 1'b0, -1);
    idle_steps(2);
    run_txn(14'h0123, 14'h0456, -1, 1'b1, -1);
    idle_steps(2);
    run_txn(14'h0A34, 14'h0018, 5, 1'b1, -1);
    idle_steps(2);
    run_txn(14'h2222, 14'h1111, 20, 1'b0, 5);
    idle_steps(3);
    run_txn(14'h0F0F, 14'h30F0, 7, 1'b0, -1);
    idle_steps(5);

    chk(ev_q.size() == 0, "scoreboard_drained", $sformatf("%0d left", ev_q.size()), "0 left");
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no end of test, want finish before time limit");
    $fatal(1, "time limit");
  end

endmodule
